// File: rtl/core_pkg.sv
// Shared core types for the execute stage, including the RV32M multiply/divide unit.
// Optional build macro MDU_FAST_MUL_EN (see mdu_iter) changes no types here.
package core_pkg;

    localparam int MDU_DIV_CYCLES = 32;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    typedef enum logic [1:0] {
        ALU_RESULT = 2'd0,
        FPU_RESULT = 2'd1,
        MDU_RESULT = 2'd2
    } alu_result_mux_t;

    // 33x33 signed product of the sign/zero-extended operands; the high word for MULH*.
    function automatic logic [31:0] mdu_mul_result(input mdu_op_t op,
                                                   input logic [31:0] a,
                                                   input logic [31:0] b);
        logic signed [32:0] a_ext;
        logic signed [32:0] b_ext;
        logic signed [63:0] prod;
        a_ext = {((op == MULH) || (op == MULHSU)) & a[31], a};
        b_ext = {(op == MULH) & b[31], b};
        prod  = a_ext * b_ext;
        case (op)
            MULH, MULHSU, MULHU: return prod[63:32];
            default:             return prod[31:0];
        endcase
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Serial radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// quotient/remainder show the value after the current step, so they are final while done=1.
module mdu_div_core
    import core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LAST_ITER = 5'(MDU_DIV_CYCLES - 1);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvsr_q;
    logic [4:0]  cnt_q;
    logic        active_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, dvsr_q};
    assign fits     = ~diff[32];
    assign rem_next = fits ? diff[31:0] : shifted[31:0];
    assign quo_next = {quo_q[30:0], fits};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            rem_q    <= '0;
            quo_q    <= dividend;
            dvsr_q   <= divisor;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done      = active_q && (cnt_q == LAST_ITER);
    assign quotient  = quo_next;
    assign remainder = rem_next;

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV32M multiply/divide unit answering the ex_stage req/gnt/rvalid/busy handshake.
// Build macro MDU_FAST_MUL_EN: multiply is computed in the accept cycle, result one cycle later.
module mdu_iter
    import core_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  mdu_op_t           op_i,
    input  logic [DWIDTH-1:0] operand_a_i,
    input  logic [DWIDTH-1:0] operand_b_i,
    input  logic              flush_i,
    output logic [DWIDTH-1:0] result_o,
    output logic              rvalid_o,
    output logic              busy_o
);

    // Handshake: an op is taken on a rising edge where req_i && gnt_o; gnt_o is high in IDLE
    // and DONE unless flush_i is high. rvalid_o is a one-cycle pulse with no back-pressure.
    mdu_state_t  state;
    mdu_op_t     op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] res_q;
    logic        neg_q;
    logic        q_neg_q;
    logic        r_neg_q;

    logic        op_is_div;
    logic        op_signed_div;
    logic        op_is_rem;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_by_zero;
    logic        div_ovf;
    logic [31:0] div_fast_val;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        rem_sel;

    assign gnt_o    = ((state == S_IDLE) || (state == S_DONE)) && !flush_i;
    assign rvalid_o = (state == S_DONE);
    assign busy_o   = (state == S_MUL) || (state == S_DIV);

    assign op_is_div     = op_i[2];
    assign op_signed_div = (op_i == DIV) || (op_i == REM);
    assign op_is_rem     = (op_i == REM) || (op_i == REMU);
    assign a_neg         = op_signed_div & operand_a_i[31];
    assign b_neg         = op_signed_div & operand_b_i[31];
    assign a_mag         = a_neg ? (~operand_a_i + 32'd1) : operand_a_i;
    assign b_mag         = b_neg ? (~operand_b_i + 32'd1) : operand_b_i;

    assign div_by_zero = (operand_b_i == 32'd0);
    assign div_ovf     = op_signed_div && (operand_a_i == 32'h8000_0000)
                         && (operand_b_i == 32'hFFFF_FFFF);

    always_comb begin
        div_fast_val = 32'd0;
        if (div_by_zero) begin
            div_fast_val = op_is_rem ? operand_a_i : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            div_fast_val = op_is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    assign div_start = req_i && gnt_o && op_is_div && !div_by_zero && !div_ovf;
    assign rem_sel   = (op_q == REM) || (op_q == REMU);

    mdu_div_core u_div (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            op_q    <= MUL;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (req_i) begin
                        op_q    <= op_i;
                        a_q     <= operand_a_i;
                        b_q     <= operand_b_i;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        if (op_is_div) begin
                            if (div_by_zero || div_ovf) begin
                                res_q <= div_fast_val;
                                neg_q <= 1'b0;
                                state <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            res_q <= mdu_mul_result(op_i, operand_a_i, operand_b_i);
                            neg_q <= 1'b0;
                            state <= S_DONE;
`else
                            state <= S_MUL;
`endif
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    res_q <= mdu_mul_result(op_q, a_q, b_q);
                    neg_q <= 1'b0;
                    state <= S_DONE;
                end
                S_DIV: begin
                    if (div_done) begin
                        res_q <= rem_sel ? div_rem : div_quo;
                        neg_q <= rem_sel ? r_neg_q : q_neg_q;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sign correction is applied on the way out so the divider only ever sees magnitudes.
    assign result_o = neg_q ? (~res_q + 32'd1) : res_q;

endmodule
